// File: rtl/mandelbrot_seq_pkg.sv
// ============================================================================
// Module  : mandelbrot_seq_pkg
// Brief   : Shared state encoding and defaults for the mandelbrot frame
//           sequencer and its offset generator.
// Options : MANDEL_SEQ_AUTOPAN_EN (per-frame offset stepping, see top)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mandelbrot_seq_pkg;

  // Sequencer states; 3-bit encoding is fixed so debug probes stay stable.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_START = 3'd3,
    S_BUSY       = 3'd4,
    S_FRAME_END  = 3'd5
  } seq_state_t;

  // Cycles the core is given to raise running after a run pulse.
  localparam int C_START_TO_DEFAULT = 8;

endpackage : mandelbrot_seq_pkg

`default_nettype wire

// File: rtl/mandelbrot_seq_offset_gen.sv
// ============================================================================
// Module  : mandelbrot_seq_offset_gen
// Brief   : cr/ci offset registers for the mandelbrot core. On each load
//           they take the base values; with MANDEL_SEQ_AUTOPAN_EN defined,
//           loads after the first frame add the step to the previous offset
//           instead, wrapping modulo 2^BITWIDTH.
// Options : MANDEL_SEQ_AUTOPAN_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mandelbrot_seq_offset_gen
  import mandelbrot_seq_pkg::*;
#(
  parameter int BITWIDTH = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
`ifdef MANDEL_SEQ_AUTOPAN_EN
  input  logic                first,
  input  logic [BITWIDTH-1:0] cr_step,
  input  logic [BITWIDTH-1:0] ci_step,
`endif
  input  logic [BITWIDTH-1:0] cr_base,
  input  logic [BITWIDTH-1:0] ci_base,
  output logic [BITWIDTH-1:0] cr_offset,
  output logic [BITWIDTH-1:0] ci_offset
);

  logic [BITWIDTH-1:0] r_cr;
  logic [BITWIDTH-1:0] r_ci;

  // Offsets change only on load so the core sees them stable for a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cr <= '0;
      r_ci <= '0;
    end else if (load) begin
`ifdef MANDEL_SEQ_AUTOPAN_EN
      if (first) begin
        r_cr <= cr_base;
        r_ci <= ci_base;
      end else begin
        // Sum is truncated to BITWIDTH, giving two's-complement wrap.
        r_cr <= r_cr + cr_step;
        r_ci <= r_ci + ci_step;
      end
`else
      r_cr <= cr_base;
      r_ci <= ci_base;
`endif
    end
  end

  assign cr_offset = r_cr;
  assign ci_offset = r_ci;

endmodule : mandelbrot_seq_offset_gen

`default_nettype wire

// File: rtl/mandelbrot_frame_sequencer.sv
// ============================================================================
// Module  : mandelbrot_frame_sequencer
// Brief   : Runs the mandelbrot iteration core over one or more frames:
//           latches host config onto the core inputs, issues a one-cycle run
//           pulse, waits for the core to start and finish, counts pixel
//           strobes and reports frame completion / start timeout.
// Options : MANDEL_SEQ_AUTOPAN_EN adds cfg_cr_step/cfg_ci_step and steps the
//           offsets every frame after the first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mandelbrot_frame_sequencer
  import mandelbrot_seq_pkg::*;
#(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 7,
  parameter int PIXW     = 16,
  parameter int START_TO = C_START_TO_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [7:0]          cfg_frames,
  input  logic [CTRWIDTH-1:0] cfg_max_ctr,
  input  logic [1:0]          cfg_scaling,
  input  logic [BITWIDTH-1:0] cfg_cr_base,
  input  logic [BITWIDTH-1:0] cfg_ci_base,
`ifdef MANDEL_SEQ_AUTOPAN_EN
  input  logic [BITWIDTH-1:0] cfg_cr_step,
  input  logic [BITWIDTH-1:0] cfg_ci_step,
`endif
  output logic                core_run,
  input  logic                core_running,
  input  logic                core_new_ctr,
  output logic [CTRWIDTH-1:0] core_max_ctr,
  output logic [1:0]          core_scaling,
  output logic [BITWIDTH-1:0] core_cr_offset,
  output logic [BITWIDTH-1:0] core_ci_offset,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_idx,
  output logic [PIXW-1:0]     pix_count,
  output logic                timeout
);

  localparam int                C_TO_W      = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [C_TO_W-1:0] C_WAIT_LAST = C_TO_W'(START_TO - 1);
  localparam logic [C_TO_W-1:0] C_WAIT_ONE  = C_TO_W'(1);
  localparam logic [PIXW-1:0]   C_PIX_ONE   = PIXW'(1);

  seq_state_t          r_state;
  seq_state_t          w_state_next;
  logic                r_stop_pending;
  logic                r_timeout;
  logic [C_TO_W-1:0]   r_wait_cnt;
  logic [7:0]          r_frame_idx;
  logic [PIXW-1:0]     r_pix_count;
  logic [CTRWIDTH-1:0] r_max_ctr;
  logic [1:0]          r_scaling;
  logic [7:0]          w_frame_idx_inc;
  logic                w_last_frame;
  logic                w_start_accept;
  logic                w_wait_expired;
  logic                w_load;

  assign w_frame_idx_inc = r_frame_idx + 8'd1;
  // A stop arriving in FRAME_END itself also ends the sequence here.
  assign w_last_frame    = r_stop_pending | stop |
                           ((cfg_frames != 8'd0) && (w_frame_idx_inc == cfg_frames));
  assign w_start_accept  = (r_state == S_IDLE) && start && !stop;
  assign w_wait_expired  = (r_state == S_WAIT_START) && !core_running &&
                           (r_wait_cnt == C_WAIT_LAST);
  assign w_load          = (r_state == S_LOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    core_run     = 1'b0;
    frame_done   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start_accept) w_state_next = S_LOAD;
      end
      S_LOAD:  w_state_next = S_ISSUE;
      S_ISSUE: begin
        // Reset gates the pulse combinationally so it drops immediately.
        core_run     = !reset;
        w_state_next = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (core_running)        w_state_next = S_BUSY;
        else if (w_wait_expired) w_state_next = S_IDLE;
      end
      S_BUSY: begin
        if (!core_running) w_state_next = S_FRAME_END;
      end
      S_FRAME_END: begin
        frame_done   = 1'b1;
        w_state_next = w_last_frame ? S_IDLE : S_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counters, sticky flags and the per-frame core configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stop_pending <= 1'b0;
      r_timeout      <= 1'b0;
      r_wait_cnt     <= '0;
      r_frame_idx    <= '0;
      r_pix_count    <= '0;
      r_max_ctr      <= '0;
      r_scaling      <= '0;
    end else begin
      if (w_state_next == S_IDLE)               r_stop_pending <= 1'b0;
      else if (stop && (r_state != S_IDLE))     r_stop_pending <= 1'b1;

      r_wait_cnt <= (r_state == S_WAIT_START) ? r_wait_cnt + C_WAIT_ONE : '0;

      if (w_start_accept) begin
        r_frame_idx <= '0;
        r_pix_count <= '0;
        r_timeout   <= 1'b0;
      end

      if (w_wait_expired) r_timeout <= 1'b1;

      if (w_load) begin
        r_max_ctr   <= cfg_max_ctr;
        r_scaling   <= cfg_scaling;
        r_pix_count <= '0;
      end

      // Count saturates so a runaway frame never reads back as small.
      if ((r_state == S_BUSY) && core_new_ctr && (r_pix_count != '1))
        r_pix_count <= r_pix_count + C_PIX_ONE;

      if (r_state == S_FRAME_END) r_frame_idx <= w_frame_idx_inc;
    end
  end

`ifdef MANDEL_SEQ_AUTOPAN_EN
  logic r_first_frame;

  // Marks the first LOAD of a sequence so offsets take the base values.
  always_ff @(posedge clk) begin
    if (reset)               r_first_frame <= 1'b0;
    else if (w_start_accept) r_first_frame <= 1'b1;
    else if (w_load)         r_first_frame <= 1'b0;
  end
`endif

  mandelbrot_seq_offset_gen #(
    .BITWIDTH (BITWIDTH)
  ) u_offset_gen (
    .clk       (clk),
    .rst       (reset),
    .load      (w_load),
`ifdef MANDEL_SEQ_AUTOPAN_EN
    .first     (r_first_frame),
    .cr_step   (cfg_cr_step),
    .ci_step   (cfg_ci_step),
`endif
    .cr_base   (cfg_cr_base),
    .ci_base   (cfg_ci_base),
    .cr_offset (core_cr_offset),
    .ci_offset (core_ci_offset)
  );

  assign core_max_ctr = r_max_ctr;
  assign core_scaling = r_scaling;
  assign frame_idx    = r_frame_idx;
  assign pix_count    = r_pix_count;
  assign timeout      = r_timeout;

endmodule : mandelbrot_frame_sequencer

`default_nettype wire

// File: tb/tb_mandelbrot_frame_sequencer.sv
// ============================================================================
// Module  : tb_mandelbrot_frame_sequencer
// Brief   : Self-checking bench for mandelbrot_frame_sequencer with a
//           behavioural core model and randomized frame sequences.
// Options : MANDEL_SEQ_AUTOPAN_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandelbrot_frame_sequencer;

  localparam int BW      = 11;
  localparam int CW      = 7;
  localparam int PW      = 5;
  localparam int STO     = 8;
  localparam int PIX_MAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic [7:0]    cfg_frames;
  logic [CW-1:0] cfg_max_ctr;
  logic [1:0]    cfg_scaling;
  logic [BW-1:0] cfg_cr_base, cfg_ci_base;
  logic [BW-1:0] cr_step, ci_step;
  logic          core_run, core_running, core_new_ctr;
  logic [CW-1:0] core_max_ctr;
  logic [1:0]    core_scaling;
  logic [BW-1:0] core_cr_offset, core_ci_offset;
  logic          busy, frame_done, timeout;
  logic [7:0]    frame_idx;
  logic [PW-1:0] pix_count;

`ifdef MANDEL_SEQ_AUTOPAN_EN
  localparam bit AUTOPAN = 1'b1;
  logic [BW-1:0] cfg_cr_step, cfg_ci_step;
  assign cfg_cr_step = cr_step;
  assign cfg_ci_step = ci_step;
`else
  localparam bit AUTOPAN = 1'b0;
`endif

  always #5 clk = ~clk;

  mandelbrot_frame_sequencer #(
    .BITWIDTH (BW), .CTRWIDTH (CW), .PIXW (PW), .START_TO (STO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .cfg_frames     (cfg_frames),
    .cfg_max_ctr    (cfg_max_ctr),
    .cfg_scaling    (cfg_scaling),
    .cfg_cr_base    (cfg_cr_base),
    .cfg_ci_base    (cfg_ci_base),
`ifdef MANDEL_SEQ_AUTOPAN_EN
    .cfg_cr_step    (cfg_cr_step),
    .cfg_ci_step    (cfg_ci_step),
`endif
    .core_run       (core_run),
    .core_running   (core_running),
    .core_new_ctr   (core_new_ctr),
    .core_max_ctr   (core_max_ctr),
    .core_scaling   (core_scaling),
    .core_cr_offset (core_cr_offset),
    .core_ci_offset (core_ci_offset),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_idx      (frame_idx),
    .pix_count      (pix_count),
    .timeout        (timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Bench-side bookkeeping and core model state.
  int tick_no = 0, run_cnt = 0, fd_cnt = 0, seq_k = 0;
  int last_run_tick = 0, last_fd_tick = 0;
  int cm_phase = 0, cm_wait = 0, cm_left = 0, cm_gap = 0;
  int cm_delay = 2, cm_n_lo = 10, cm_n_hi = 10;
  bit cm_overlap_en = 1'b0, cm_ov = 1'b0;
  int exp_pix = 0;
  logic [CW-1:0] exp_max;
  logic [1:0]    exp_scal;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Offset the core should see on frame k of a sequence.
  function automatic logic [BW-1:0] exp_off(input logic [BW-1:0] base,
                                            input logic [BW-1:0] step, input int k);
    int v;
    if (!AUTOPAN) return base;
    v = (int'(base) + k * int'(step)) % (1 << BW);
    return v[BW-1:0];
  endfunction

  // One clock: observe outputs just after the edge, then step the core model.
  task automatic tick();
    int n;
    @(posedge clk); #1;
    tick_no++;
    if (core_run) begin
      run_cnt++;
      last_run_tick = tick_no;
      check("run_max_ctr", 32'(core_max_ctr), 32'(exp_max));
      check("run_scaling", 32'(core_scaling), 32'(exp_scal));
      check("run_cr_off", 32'(core_cr_offset), 32'(exp_off(cfg_cr_base, cr_step, seq_k)));
      check("run_ci_off", 32'(core_ci_offset), 32'(exp_off(cfg_ci_base, ci_step, seq_k)));
      seq_k++;
      n       = int'($urandom_range(cm_n_hi, cm_n_lo));
      cm_left = n;
      exp_pix = (n > PIX_MAX) ? PIX_MAX : n;
      cm_gap  = 0;
      cm_ov   = cm_overlap_en && (n > 0) && ($urandom_range(1, 0) == 1);
      core_running = 1'b0;
      core_new_ctr = 1'b0;
      if (cm_delay >= 1) begin
        cm_phase = 1;
        cm_wait  = cm_delay;
      end
    end else begin
      case (cm_phase)
        1: begin
          core_new_ctr = 1'b0;
          if (cm_wait <= 1) begin
            core_running = 1'b1;
            cm_phase     = 2;
          end else begin
            cm_wait--;
          end
        end
        2: begin
          if (cm_gap > 0) begin
            core_new_ctr = 1'b0;
            cm_gap--;
          end else if (cm_left == 1 && cm_ov) begin
            core_running = 1'b0;
            core_new_ctr = 1'b1;
            cm_left      = 0;
            cm_phase     = 0;
          end else if (cm_left > 0) begin
            core_new_ctr = 1'b1;
            cm_left--;
            cm_gap = int'($urandom_range(2, 0));
          end else begin
            core_running = 1'b0;
            core_new_ctr = 1'b0;
            cm_phase     = 0;
          end
        end
        default: begin
          core_running = 1'b0;
          core_new_ctr = 1'b0;
        end
      endcase
    end
    if (frame_done) begin
      fd_cnt++;
      last_fd_tick = tick_no;
      check("frame_pix", 32'(pix_count), 32'(exp_pix));
      exp_max  = cfg_max_ctr;
      exp_scal = cfg_scaling;
    end
  endtask

  task automatic start_seq();
    exp_max  = cfg_max_ctr;
    exp_scal = cfg_scaling;
    seq_k    = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 2000) begin
      tick();
      i++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_busy_phase(input int runs_target, input string tag);
    int i = 0;
    while (!(run_cnt >= runs_target && cm_phase == 2) && i < 500) begin
      tick();
      i++;
    end
    check(tag, 32'(cm_phase), 32'd2);
  endtask

  task automatic randomize_cfg();
    cfg_max_ctr = CW'($urandom);
    cfg_scaling = 2'($urandom);
    cfg_cr_base = BW'($urandom);
    cfg_ci_base = BW'($urandom);
    cr_step     = BW'($urandom);
    ci_step     = BW'($urandom);
  endtask

  initial begin
    int r0, f0, nf;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    core_running = 1'b0; core_new_ctr = 1'b0;
    cfg_frames = 8'd1;
    randomize_cfg();
    exp_max = '0; exp_scal = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_outs", {core_run, frame_done, timeout, frame_idx, 3'b0, pix_count},
          32'd0);
    check("rst_core", {core_max_ctr, core_scaling, core_cr_offset, core_ci_offset},
          32'd0);
    reset = 1'b0;
    tick();

    // Single frame, 10 pixels.
    cfg_frames = 8'd1; cm_delay = 2; cm_n_lo = 10; cm_n_hi = 10; cm_overlap_en = 1'b0;
    r0 = run_cnt; f0 = fd_cnt;
    start_seq();
    wait_idle("t1_idle");
    check("t1_runs", run_cnt - r0, 1);
    check("t1_fdone", fd_cnt - f0, 1);
    check("t1_pix", 32'(pix_count), 10);
    check("t1_fidx", 32'(frame_idx), 1);
    check("t1_busy_fall", tick_no - last_fd_tick, 1);

    // Three frames with cr offset crossing the wrap point.
    randomize_cfg();
    cfg_cr_base = 11'h7FE; cr_step = 11'h001;
    cfg_frames = 8'd3; cm_n_lo = 0; cm_n_hi = 12; cm_overlap_en = 1'b1;
    r0 = run_cnt; f0 = fd_cnt;
    start_seq();
    wait_idle("t2_idle");
    check("t2_runs", run_cnt - r0, 3);
    check("t2_fdone", fd_cnt - f0, 3);
    check("t2_fidx", 32'(frame_idx), 3);
    check("t2_cr_last", 32'(core_cr_offset), AUTOPAN ? 32'h000 : 32'h7FE);

    // Continuous mode, stop during the second frame.
    cfg_frames = 8'd0; cm_n_lo = 4; cm_n_hi = 8;
    r0 = run_cnt; f0 = fd_cnt;
    start_seq();
    wait_busy_phase(r0 + 2, "t3_reach");
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("t3_idle");
    repeat (4) tick();
    check("t3_runs", run_cnt - r0, 2);
    check("t3_fidx", 32'(frame_idx), 2);
    check("t3_fdone", fd_cnt - f0, 2);

    // Core never starts: timeout after START_TO waiting cycles.
    cfg_frames = 8'd1; cm_delay = -1;
    f0 = fd_cnt;
    start_seq();
    wait_idle("t4_idle");
    check("t4_timeout", 32'(timeout), 1);
    check("t4_to_cycles", tick_no - last_run_tick, STO + 1);
    check("t4_fdone", fd_cnt - f0, 0);

    // Core starts on the last allowed waiting cycle: no timeout.
    cm_delay = STO;
    f0 = fd_cnt;
    start_seq();
    check("t5_to_clear", 32'(timeout), 0);
    wait_idle("t5_idle");
    check("t5_timeout", 32'(timeout), 0);
    check("t5_fdone", fd_cnt - f0, 1);
    cm_delay = 2;

    // start and stop together in IDLE: nothing happens.
    r0 = run_cnt;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    repeat (4) tick();
    check("t6_busy", 32'(busy), 0);
    check("t6_runs", run_cnt - r0, 0);

    // start while BUSY is ignored.
    cfg_frames = 8'd1;
    r0 = run_cnt; f0 = fd_cnt;
    start_seq();
    wait_busy_phase(r0 + 1, "t7_reach");
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("t7_idle");
    repeat (4) tick();
    check("t7_runs", run_cnt - r0, 1);
    check("t7_fdone", fd_cnt - f0, 1);

    // Reset during BUSY with a stop pending; the pending stop must be dropped.
    cfg_frames = 8'd0;
    r0 = run_cnt;
    start_seq();
    wait_busy_phase(r0 + 1, "t8_reach");
    stop = 1'b1; tick(); stop = 1'b0;
    reset = 1'b1;
    cm_phase = 0; core_running = 1'b0; core_new_ctr = 1'b0;
    tick();
    check("t8_busy", 32'(busy), 0);
    check("t8_outs", {core_run, frame_done, timeout, frame_idx, 3'b0, pix_count}, 32'd0);
    check("t8_core", {core_max_ctr, core_scaling, core_cr_offset, core_ci_offset}, 32'd0);
    reset = 1'b0;
    tick();
    cfg_frames = 8'd2;
    r0 = run_cnt; f0 = fd_cnt;
    start_seq();
    wait_idle("t8b_idle");
    check("t8b_fdone", fd_cnt - f0, 2);
    check("t8b_fidx", 32'(frame_idx), 2);

    // cfg_max_ctr change mid frame only lands at the next LOAD.
    cfg_frames = 8'd2; cfg_max_ctr = 7'h20; cm_n_lo = 6; cm_n_hi = 9;
    r0 = run_cnt;
    start_seq();
    wait_busy_phase(r0 + 1, "t9_reach");
    cfg_max_ctr = 7'h40;
    tick();
    check("t9_hold", 32'(core_max_ctr), 32'h20);
    wait_idle("t9_idle");
    check("t9_new", 32'(core_max_ctr), 32'h40);
    check("t9_runs", run_cnt - r0, 2);

    // pix_count saturation.
    cfg_frames = 8'd1; cm_n_lo = 40; cm_n_hi = 40;
    start_seq();
    wait_idle("t10_idle");
    check("t10_sat", 32'(pix_count), PIX_MAX);

    // Randomized sequences.
    cm_n_lo = 0; cm_n_hi = 15;
    for (int it = 0; it < 8; it++) begin
      randomize_cfg();
      nf = int'($urandom_range(4, 1));
      cfg_frames = 8'(nf);
      cm_delay = int'($urandom_range(STO, 1));
      cm_overlap_en = ($urandom_range(1, 0) == 1);
      r0 = run_cnt; f0 = fd_cnt;
      start_seq();
      wait_idle("rnd_idle");
      check("rnd_runs", run_cnt - r0, nf);
      check("rnd_fdone", fd_cnt - f0, nf);
      check("rnd_fidx", 32'(frame_idx), 32'(nf));
      check("rnd_timeout", 32'(timeout), 0);
      repeat (2) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mandelbrot_frame_sequencer

`default_nettype wire
